// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// uart_tx_arbiter : two-requester round-robin arbiter driving one 8N1 UART TX
// Revision 1.0
// ============================================================================
module uart_tx_arbiter #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 9600,
    parameter int DATA_BITS = 8
) (
    input  logic                 sys_clk,
    input  logic                 reset,
    input  logic                 req0_valid,
    input  logic [DATA_BITS-1:0] req0_data,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [DATA_BITS-1:0] req1_data,
    output logic                 req1_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 grant_id,
    output logic                 frame_done
);

    localparam int          BIT_TICKS = CLK_FREQ / BAUD_RATE;
    localparam logic [15:0] LAST_TICK = 16'(BIT_TICKS - 1);
    localparam logic [2:0]  LAST_BIT  = 3'(DATA_BITS - 1);

    generate
        if (BIT_TICKS < 2 || BIT_TICKS > 65535) begin : g_bad_ticks
            $error("uart_tx_arbiter: CLK_FREQ/BAUD_RATE must be within 2..65535");
        end
        if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_bits
            $error("uart_tx_arbiter: DATA_BITS must be within 5..8");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [2:0]            idx_q, idx_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic                  last_q, last_d;
    logic                  grant_q, grant_d;
    logic                  tx_q, tx_d;
    logic                  done_q, done_d;
    logic                  tick;
    logic                  win;

    assign tick = (cnt_q == LAST_TICK);
    // Contention goes to whoever did not own the previous frame.
    assign win  = (req0_valid && req1_valid) ? ~last_q : req1_valid;

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            last_q  <= 1'b1;
            grant_q <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        last_d     = last_q;
        grant_d    = grant_q;
        done_d     = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        cnt_d      = (state_q == S_IDLE || tick) ? 16'd0 : cnt_q + 16'd1;

        case (state_q)
            S_IDLE: begin
                req0_ready = reset & req0_valid & ~win;
                req1_ready = reset & req1_valid & win;
                if (req0_ready || req1_ready) begin
                    shift_d = win ? req1_data : req0_data;
                    last_d  = win;
                    grant_d = win;
                    idx_d   = 3'd0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (tick) state_d = S_DATA;
            end
            S_DATA: begin
                if (tick) begin
                    if (idx_q == LAST_BIT) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        shift_d = shift_q >> 1;
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Line level is registered from the upcoming state so it lines up with it.
        tx_d = 1'b1;
        if (state_d == S_START) begin
            tx_d = 1'b0;
        end else if (state_d == S_DATA) begin
            tx_d = shift_d[0];
        end
    end

    assign tx         = tx_q;
    assign busy       = (state_q != S_IDLE);
    assign grant_id   = grant_q;
    assign frame_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// Bench for uart_tx_arbiter: frame-level reference model plus directed and random traffic.
module tb_uart_tx_arbiter;

    localparam int CF = 160;
    localparam int BR = 10;
    localparam int T  = 16;
    localparam int DB = 8;
    localparam int FRAME = (DB + 2) * T;

    logic       sys_clk = 1'b0;
    logic       reset   = 1'b0;
    logic       v0 = 1'b0, v1 = 1'b0;
    logic [7:0] d0 = '0, d1 = '0;
    logic       r0, r1, tx, busy, gid, fdone;

    logic       v5a = 1'b0, v5b = 1'b0;
    logic [4:0] d5a = '0, d5b = '0;
    logic       r5a, r5b, tx5, busy5, gid5, fdone5;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_r0   = 0;
    int n_r1   = 0;

    // Reference model state: one frame in flight, described by its line bits and age.
    bit         m_active = 1'b0;
    int         m_t      = 0;
    logic [9:0] m_frame  = '1;
    bit         m_last   = 1'b1;
    bit         m_grant  = 1'b0;
    bit         m_done   = 1'b0;
    bit         m_hs0    = 1'b0;
    bit         m_hs1    = 1'b0;

    uart_tx_arbiter #(.CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(DB)) u_dut (
        .sys_clk(sys_clk), .reset(reset),
        .req0_valid(v0), .req0_data(d0), .req0_ready(r0),
        .req1_valid(v1), .req1_data(d1), .req1_ready(r1),
        .tx(tx), .busy(busy), .grant_id(gid), .frame_done(fdone)
    );

    uart_tx_arbiter #(.CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(5)) u_dut5 (
        .sys_clk(sys_clk), .reset(reset),
        .req0_valid(v5a), .req0_data(d5a), .req0_ready(r5a),
        .req1_valid(v5b), .req1_data(d5b), .req1_ready(r5b),
        .tx(tx5), .busy(busy5), .grant_id(gid5), .frame_done(fdone5)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out (cycle %0d)", name, cyc);
    endtask

    always @(negedge sys_clk) begin
        bit w, e0, e1, nd;
        cyc++;
        if (r0) n_r0++;
        if (r1) n_r1++;
        if (!reset) begin
            chk("rst_tx", tx, 1);
            chk("rst_busy", busy, 0);
            chk("rst_done", fdone, 0);
            chk("rst_ready0", r0, 0);
            chk("rst_ready1", r1, 0);
            chk("rst_grant", gid, 0);
            m_active = 0; m_t = 0; m_last = 1; m_grant = 0;
            m_done = 0; m_hs0 = 0; m_hs1 = 0;
        end else begin
            w  = (v0 && v1) ? !m_last : v1;
            e0 = !m_active && v0 && !w;
            e1 = !m_active && v1 && w;
            chk("tx", tx, m_active ? m_frame[m_t / T] : 1'b1);
            chk("busy", busy, m_active);
            chk("grant_id", gid, m_grant);
            chk("frame_done", fdone, m_done);
            chk("ready0", r0, e0);
            chk("ready1", r1, e1);
            m_hs0 = e0;
            m_hs1 = e1;
            nd = 0;
            if (m_active) begin
                m_t++;
                if (m_t == FRAME) begin
                    m_active = 0;
                    nd = 1;
                end
            end else if (e0 || e1) begin
                m_active = 1;
                m_t      = 0;
                m_frame  = {1'b1, (w ? d1 : d0), 1'b0};
                m_grant  = w;
                m_last   = w;
            end
            m_done = nd;
        end
    end

    task automatic wait_hs(input int budget, output int which, output int at);
        bool_loop: begin
            which = -1;
            at    = -1;
            for (int i = 0; i < budget; i++) begin
                @(negedge sys_clk); #1;
                if (m_hs0 || m_hs1) begin
                    which = m_hs0 ? 0 : 1;
                    at    = cyc;
                    disable bool_loop;
                end
            end
            timeout("handshake");
        end
    endtask

    task automatic wait_idle(input int budget);
        bool_loop: begin
            for (int i = 0; i < budget; i++) begin
                @(negedge sys_clk); #1;
                if (!m_active) disable bool_loop;
            end
            timeout("idle");
        end
    endtask

    // Called in the cycle after the handshake; samples each bit at its midpoint.
    task automatic sample_frame(output logic [9:0] bits);
        bits = '0;
        for (int k = 0; k < DB + 2; k++) begin
            repeat (k == 0 ? 9 : 16) @(negedge sys_clk);
            #1;
            bits[k] = tx;
        end
    endtask

    initial begin
        int         which, at, prev, n0, n1, dn;
        logic [9:0] bits;
        logic [7:0] bytes [3];
        logic [6:0] bits5;
        int         cnt5, rel;
        bit         seen;
        bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h80;

        // Both requesters valid out of reset: req0 first, req1 after one idle cycle.
        v0 = 1; d0 = 8'h11; v1 = 1; d1 = 8'h22;
        repeat (3) @(posedge sys_clk);
        #1 reset = 1;
        wait_hs(5, which, at);
        chk("t2_first", which, 0);
        prev = at;
        @(posedge sys_clk); #1 v0 = 0;
        chk("t2_grant0", gid, 0);
        wait_hs(FRAME + 10, which, at);
        chk("t2_second", which, 1);
        chk("t2_gap", at - prev, FRAME + 1);
        @(posedge sys_clk); #1;
        chk("t2_grant1", gid, 1);

        // Continuous contention alternates owners.
        v0 = 1; d0 = 8'($urandom); d1 = 8'($urandom);
        n0 = n_r0; n1 = n_r1;
        for (int f = 0; f < 4; f++) begin
            wait_hs(FRAME + 10, which, at);
            chk("t3_alternate", which, f % 2);
            if (f == 3) begin
                chk("t3_ready0_count", n_r0 - n0, 2);
                chk("t3_ready1_count", n_r1 - n1, 2);
            end
            @(posedge sys_clk); #1;
            if (which == 0) d0 = 8'($urandom); else d1 = 8'($urandom);
        end
        v0 = 0; v1 = 0;
        wait_idle(FRAME + 10);

        // Single request of 8'hA5.
        @(posedge sys_clk); #1 v0 = 1; d0 = 8'hA5;
        n0 = n_r0;
        wait_hs(5, which, at);
        chk("t1_owner", which, 0);
        @(posedge sys_clk); #1 v0 = 0;
        chk("t1_grant", gid, 0);
        sample_frame(bits);
        chk("t1_bits", bits, 10'b11_0100_1010);
        chk("t1_ready_pulses", n_r0 - n0, 1);
        dn = 0; seen = 0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge sys_clk); #1;
            if (fdone) begin dn = i; seen = 1; end
        end
        chk("t1_done_delay", dn, 8);

        // req1 alone, three back-to-back bytes.
        prev = 0;
        for (int j = 0; j < 3; j++) begin
            if (j == 0) begin
                @(posedge sys_clk); #1 v1 = 1; d1 = bytes[0];
            end
            wait_hs(FRAME + 10, which, at);
            chk("t4_owner", which, 1);
            if (j > 0) chk("t4_gap", at - prev, FRAME + 1);
            prev = at;
            @(posedge sys_clk); #1;
            if (j < 2) d1 = bytes[j + 1]; else v1 = 0;
            sample_frame(bits);
            chk("t4_start", bits[0], 0);
            chk("t4_byte", bits[8:1], bytes[j]);
            chk("t4_stop", bits[9], 1);
        end
        wait_idle(FRAME + 10);

        // Reset 40 cycles into a frame, then contention restarts with req0 priority.
        @(posedge sys_clk); #1 v1 = 1; d1 = 8'h3C;
        wait_hs(5, which, at);
        @(posedge sys_clk); #1 v1 = 0;
        repeat (39) @(posedge sys_clk);
        #1 reset = 0;
        #1;
        chk("t5_tx_high", tx, 1);
        chk("t5_busy_low", busy, 0);
        v0 = 1; d0 = 8'h5A; v1 = 1; d1 = 8'hC3;
        repeat (3) @(posedge sys_clk);
        #1 reset = 1;
        rel = cyc;
        wait_hs(5, which, at);
        chk("t5_req0_wins", which, 0);
        chk("t5_immediate", at, rel + 1);
        chk("t5_ready0_pin", r0, 1);
        @(posedge sys_clk); #1 v0 = 0;

        // Random traffic; requesters hold valid/data until their handshake.
        for (int c = 0; c < 4000; c++) begin
            @(posedge sys_clk); #1;
            if (v0 && m_hs0) begin
                v0 = 1'($urandom_range(0, 1)); d0 = 8'($urandom);
            end else if (!v0 && $urandom_range(0, 3) == 0) begin
                v0 = 1; d0 = 8'($urandom);
            end
            if (v1 && m_hs1) begin
                v1 = 1'($urandom_range(0, 1)); d1 = 8'($urandom);
            end else if (!v1 && $urandom_range(0, 3) == 0) begin
                v1 = 1; d1 = 8'($urandom);
            end
        end
        v0 = 0; v1 = 0;
        wait_idle(FRAME + 10);

        // Five-bit frame on the second instance.
        @(posedge sys_clk); #1 v5a = 1; d5a = 5'h13;
        seen = 0;
        for (int i = 0; i < 5 && !seen; i++) begin
            @(negedge sys_clk); #1;
            if (r5a) seen = 1;
        end
        if (!seen) timeout("t6_handshake");
        @(posedge sys_clk); #1 v5a = 0;
        bits5 = '0; cnt5 = 0; seen = 0;
        for (int i = 1; i <= 300 && !seen; i++) begin
            @(negedge sys_clk); #1;
            if (busy5) begin
                cnt5++;
                if ((i - 1) % 16 == 8 && (i - 1) / 16 < 7) bits5[(i - 1) / 16] = tx5;
            end else begin
                seen = 1;
                chk("t6_done", fdone5, 1);
            end
        end
        chk("t6_length", cnt5, 112);
        chk("t6_bits", bits5, 7'b110_0110);
        chk("t6_grant", gid5, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART serial transmit line between two byte requesters.
- Round-robin arbitration selects a requester. The block then serialises that requester's byte as 8N1: 1 start bit, DATA_BITS data bits LSB-first, 1 stop bit.
- Bit timing comes from an internal bit-period counter derived from the same CLK_FREQ/BAUD_RATE parameters used by the baud generator.
- Sits between the command/telemetry sources and the board TX pin.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD_RATE, 9600, serial bit rate in baud.
- DATA_BITS, 8, data bits per frame; legal range 5..8.

Ports:
- sys_clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- req0_valid  input  1  requester 0 has a byte to send.
- req0_data  input  DATA_BITS  requester 0 byte.
- req0_ready  output  1  requester 0 byte accepted this cycle.
- req1_valid  input  1  requester 1 has a byte to send.
- req1_data  input  DATA_BITS  requester 1 byte.
- req1_ready  output  1  requester 1 byte accepted this cycle.
- tx  output  1  serial line; idle high.
- busy  output  1  frame in progress.
- grant_id  output  1  owner of the current or most recent frame.
- frame_done  output  1  one-cycle pulse at end of stop bit.

Behaviour:
- One clock domain. Reset is asynchronous and active-low.
- Reset values:
  - tx=1, busy=0, grant_id=0, frame_done=0, req0_ready=0, req1_ready=0.
  - state=IDLE, bit counter=0, bit index=0, last_grant=1, so req0 wins the first contention.
- Bit timing:
  - BIT_TICKS = CLK_FREQ/BAUD_RATE (integer division).
  - 16-bit cycle counter counts 0..BIT_TICKS-1; the bit boundary is at BIT_TICKS-1.
  - Counter is cleared whenever the FSM enters a new state.
  - BIT_TICKS must be at least 2 and at most 65535; elaboration error otherwise.
- Handshake:
  - reqN_ready is combinational. It is high only in IDLE, and only for the requester selected by the arbiter.
  - Transfer occurs when reqN_valid & reqN_ready.
  - Requesters must hold valid and data stable until ready.
  - At most one ready is high per cycle.
- Arbitration, evaluated in IDLE only:
  - Only one valid: grant it.
  - Both valid: grant the requester that is not last_grant.
  - Neither valid: stay IDLE.
  - On transfer: latch data into the shift register, set last_grant and grant_id to the winner, go to START.
- FSM states:
  - IDLE: tx=1, busy=0.
  - START: tx=0 for BIT_TICKS cycles, then DATA. tx is registered, so it falls the cycle after the handshake.
  - DATA: tx=shift[0] for BIT_TICKS cycles per bit, then shift right and increment the bit index. After bit DATA_BITS-1, go to STOP.
  - STOP: tx=1 for BIT_TICKS cycles. On the final cycle, frame_done=1 for one cycle and the FSM returns to IDLE.
- busy=1 in START, DATA and STOP.
- Frame length is exactly (DATA_BITS+2)*BIT_TICKS cycles of non-idle line time.
- Back-to-back frames: the minimum gap is 1 IDLE cycle, the handshake cycle, between a frame_done and the next start bit.
- Valid changes during a frame are ignored; no ready is issued until IDLE.
- Reset mid-frame: the line returns high immediately, asynchronously. The partial frame is dropped, and arbitration restarts with req0 priority.
- grant_id holds its value after the frame ends, until the next grant.

Test Plan:
- Sim parameters: CLK_FREQ=160, BAUD_RATE=10, giving BIT_TICKS=16. Tests 1–5 run with DATA_BITS=8.
1. Single request, req0_data=8'hA5 → req0_ready pulses 1 cycle. tx bits are 0,1,0,1,0,0,1,0,1,1, each 16 cycles. frame_done fires 160 cycles after tx falls. grant_id=0.
2. Both valid from reset, req0=8'h11, req1=8'h22 → req0 served first, then req1 after a 1-cycle gap. grant_id sequence is 0 then 1.
3. Both continuously valid for 4 frames → grants alternate 0,1,0,1. Each ready is high for exactly one cycle per frame.
4. req1 only, three back-to-back bytes 8'h00, 8'hFF, 8'h80 → each frame is 160 line cycles with a 1-cycle idle gap, and the bytes decode correctly at the bit midpoints.
5. Reset asserted 40 cycles into a frame → tx=1 and busy=0 in the same cycle. After release with both valid, req0 wins.
6. DATA_BITS=5 with data 5'h13 → the frame is 7*16 = 112 cycles and the stop bit follows bit 4.
